// File: rtl/log2_seq_pkg.sv
// Shared types and sizing helpers for the sequential log2 engine.
// The result-width function lets benches and wrappers size their buses to match the engine.
package log2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } log2_state_e;

    // Q(INT_W.FRAC_W) result width for a DATA_W-bit unsigned operand.
    function automatic int res_w(input int data_w, input int frac_w);
        return $clog2(data_w) + frac_w;
    endfunction

endpackage

// File: rtl/log2_seq_if.sv
// Valid/ready operand and result stream for the log2 engine.
// The engine takes the slave side; producers and consumers take the master side.
interface log2_seq_if
    import log2_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
);
    localparam int OUT_W = res_w(DATA_W, FRAC_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_err;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/log2_seq_msb_enc.sv
// Combinational priority encoder: index of the most significant set bit plus a zero flag.
// Index is 0 when the input is zero; callers must qualify it with o_zero.
module log2_msb_enc #(
    parameter int DATA_W = 16,
    parameter int INT_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [INT_W-1:0]  o_idx,
    output logic              o_zero
);

    always_comb begin
        o_idx = '0;
        // Ascending scan so the highest set bit wins.
        for (int i = 0; i < DATA_W; i++) begin
            if (i_data[i]) begin
                o_idx = INT_W'(i);
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule

// File: rtl/log2_seq.sv
// Sequential unsigned log2: leading-one detect for the integer part, then repeated
// mantissa squaring producing one fractional bit per cycle, MSB first, truncated.
module log2_seq
    import log2_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int GUARD_W = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    log2_seq_if.slave   bus
);

    localparam int INT_W  = $clog2(DATA_W);
    localparam int OUT_W  = res_w(DATA_W, FRAC_W);
    localparam int MANT_W = FRAC_W + GUARD_W;
    localparam int MW1    = MANT_W + 1;
    localparam int NW     = DATA_W + MANT_W;
    localparam int CNT_W  = (FRAC_W > 1) ? $clog2(FRAC_W) : 1;

    log2_state_e       r_state;
    log2_state_e       w_state_next;

    logic [DATA_W-1:0] r_x;
    logic [INT_W-1:0]  r_int;
    logic [FRAC_W-1:0] r_frac;
    logic [MW1-1:0]    r_mant;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic              r_out_err;

    logic [INT_W-1:0]  w_idx;
    logic              w_zero;
    logic [INT_W-1:0]  w_shift;
    logic [NW-1:0]     w_norm_wide;
    logic [MW1-1:0]    w_mant_norm;
    logic [2*MW1-1:0]  w_sq;
    logic              w_sq_ge2;
    logic [MW1-1:0]    w_mant_next;

    log2_msb_enc #(
        .DATA_W (DATA_W),
        .INT_W  (INT_W)
    ) u_msb_enc (
        .i_data (r_x),
        .o_idx  (w_idx),
        .o_zero (w_zero)
    );

    // Left-justify X so its MSB lands on the mantissa's integer bit; zeros fill below.
    assign w_shift     = INT_W'(DATA_W - 1) - w_idx;
    assign w_norm_wide = {r_x, {MANT_W{1'b0}}} << w_shift;
    assign w_mant_norm = MW1'(w_norm_wide >> (DATA_W - 1));

    // M in [1,2) with MANT_W fraction bits, so M*M carries 2*MANT_W fraction bits.
    assign w_sq        = {{MW1{1'b0}}, r_mant} * {{MW1{1'b0}}, r_mant};
    assign w_sq_ge2    = w_sq[2*MANT_W+1];
    assign w_mant_next = w_sq_ge2 ? MW1'(w_sq >> (MANT_W + 1))
                                  : MW1'(w_sq >> MANT_W);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (bus.in_valid) w_state_next = NORM;
            NORM: w_state_next = w_zero ? DONE : ITER;
            ITER: if (r_cnt == '0) w_state_next = DONE;
            DONE: if (r_out_valid && bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x         <= '0;
            r_int       <= '0;
            r_frac      <= '0;
            r_mant      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x <= bus.in_data;
                    end
                end
                NORM: begin
                    r_int  <= w_zero ? '0 : w_idx;
                    r_frac <= '0;
                    r_mant <= w_mant_norm;
                    r_cnt  <= CNT_W'(FRAC_W - 1);
                    r_err  <= w_zero;
                end
                ITER: begin
                    r_frac <= (r_frac << 1) | FRAC_W'(w_sq_ge2);
                    r_mant <= w_mant_next;
                    r_cnt  <= r_cnt - 1'b1;
                end
                DONE: begin
                    // Publish once on DONE entry, then hold until the consumer takes it.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= {r_int, r_frac};
                        r_out_err   <= r_err;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_log2_seq.sv
// Directed bench for log2_seq (DATA_W=16, FRAC_W=8, GUARD_W=4) against hand-computed values.
module tb_log2_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    log2_seq_if #(.DATA_W(16), .FRAC_W(8)) bus ();

    log2_seq #(
        .DATA_W  (16),
        .FRAC_W  (8),
        .GUARD_W (4)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    // One accepted operand, result collected with immediate out_ready; lat=-1 on timeout.
    task automatic run_op(input logic [15:0] x, output logic [11:0] d,
                          output logic e, output int lat);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        bus.in_data  = x;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        d = bus.out_data;
        e = bus.out_err;
        if (lat >= 100) lat = -1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        $display("op X=%0d data=0x%03h err=%0b lat=%0d", x, d, e, lat);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 12'h000) begin n_bad++; $display("FAIL reset_out_data got=0x%03h want=0x000", bus.out_data); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got=%b want=0", bus.out_err); end
    endtask

    task automatic test_exact();
        logic [11:0] d; logic e; int lat;
        run_op(16'd1, d, e, lat);
        n_cmp++; if (d !== 12'h000) begin n_bad++; $display("FAIL x1_data got=0x%03h want=0x000", d); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL x1_err got=%b want=0", e); end
        n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL x1_latency got=%0d want=10", lat); end
        run_op(16'd8, d, e, lat);
        n_cmp++; if (d !== 12'h300) begin n_bad++; $display("FAIL x8_data got=0x%03h want=0x300", d); end
        run_op(16'd32768, d, e, lat);
        n_cmp++; if (d !== 12'hF00) begin n_bad++; $display("FAIL x32768_data got=0x%03h want=0xF00", d); end
        n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL x32768_latency got=%0d want=10", lat); end
    endtask

    task automatic test_fraction();
        logic [11:0] d; logic e; int lat;
        run_op(16'd3, d, e, lat);
        n_cmp++; if (d !== 12'h195 && d !== 12'h194) begin n_bad++; $display("FAIL x3_data got=0x%03h want=0x195|0x194", d); end
        run_op(16'd65535, d, e, lat);
        n_cmp++; if (d !== 12'hFFF && d !== 12'hFFE) begin n_bad++; $display("FAIL x65535_data got=0x%03h want=0xFFF|0xFFE", d); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL x65535_err got=%b want=0", e); end
    endtask

    task automatic test_zero();
        logic [11:0] d; logic e; int lat;
        run_op(16'd0, d, e, lat);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL x0_err got=%b want=1", e); end
        n_cmp++; if (d !== 12'h000) begin n_bad++; $display("FAIL x0_data got=0x%03h want=0x000", d); end
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL x0_latency got=%0d want=2", lat); end
        run_op(16'd2, d, e, lat);
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL x2_err got=%b want=0", e); end
        n_cmp++; if (d !== 12'h100) begin n_bad++; $display("FAIL x2_data got=0x%03h want=0x100", d); end
    endtask

    task automatic test_backpressure();
        int lat; int extra; int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        bus.in_data  = 16'd8;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // Toggle in_valid with a different operand while busy; none may be taken.
        bus.in_data = 16'd5;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            bus.in_valid = ~bus.in_valid;
            @(posedge clk); #1; lat++;
        end
        n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL bp_latency got=%0d want=10", lat); end
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid c=%0d got=%b want=1", c, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 12'h300) begin n_bad++; $display("FAIL bp_hold_data c=%0d got=0x%03h want=0x300", c, bus.out_data); end
            n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL bp_hold_err c=%0d got=%b want=0", c, bus.out_err); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_in_ready c=%0d got=%b want=0", c, bus.in_ready); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        $display("op X=8 held data=0x%03h lat=%0d", 12'h300, lat);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got=%b want=0", bus.out_valid); end
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) extra++;
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL bp_extra_results got=%0d want=0", extra); end
    endtask

    task automatic test_midreset();
        logic [11:0] d; logic e; int lat; int stale; int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        bus.in_data  = 16'd1000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mr_in_ready got=%b want=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 12'h000) begin n_bad++; $display("FAIL mr_out_data got=0x%03h want=0x000", bus.out_data); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL mr_out_err got=%b want=0", bus.out_err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL mr_stale_valid got=%0d want=0", stale); end
        run_op(16'd1000, d, e, lat);
        n_cmp++; if (d !== 12'h9F7 && d !== 12'h9F6) begin n_bad++; $display("FAIL x1000_data got=0x%03h want=0x9F7|0x9F6", d); end
        n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL x1000_latency got=%0d want=10", lat); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_exact();
        test_fraction();
        test_zero();
        test_backpressure();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
